// File: rtl/enc_expgob.sv
// rtl/enc_expgob.sv - serial order-0 Exp-Golomb encoder, one codeword bit per transfer
// Optional ENC_SIGNED_MAP_EN: treat data_i as signed and apply the se(v) mapping.
module enc_expgob #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(2*DATA_W+2)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              bit_o,
    output logic              bit_vld_o,
    input  logic              bit_rdy_i,
    output logic              last_o,
    output logic [CNT_W-1:0]  len_o,
    output logic [CNT_W-1:0]  idx_o
);

    typedef enum logic [1:0] {S_IDLE, S_PREFIX, S_SUFFIX} state_t;

    state_t             r_state;
    logic [DATA_W:0]    r_x;
    logic [CNT_W-1:0]   r_n;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W:0]    w_x;
    logic [CNT_W-1:0]   w_n;
    logic               w_xfer;
    logic [CNT_W-1:0]   w_idx_dec;

    function automatic logic [CNT_W-1:0] f_msb(input logic [DATA_W:0] x);
        f_msb = '0;
        for (int i = 0; i <= DATA_W; i++) begin
            if (x[i]) f_msb = CNT_W'(i);
        end
    endfunction

    function automatic logic f_bit(input logic [DATA_W:0] x, input logic [CNT_W-1:0] sel);
        logic [DATA_W:0] t;
        t     = x >> sel;
        f_bit = t[0];
    endfunction

`ifdef ENC_SIGNED_MAP_EN
    // x = mapped+1: k>0 gives 2k, k<=0 gives 2|k|+1; |k| of the most negative value still fits DATA_W bits
    logic [DATA_W-1:0] w_mag;
    logic              w_nonpos;
    assign w_mag    = (~data_i) + {{(DATA_W-1){1'b0}}, 1'b1};
    assign w_nonpos = data_i[DATA_W-1] | (data_i == '0);
    assign w_x      = w_nonpos ? {w_mag, 1'b1} : {data_i, 1'b0};
`else
    assign w_x = {1'b0, data_i} + {{DATA_W{1'b0}}, 1'b1};
`endif

    assign w_n       = f_msb(w_x);
    assign w_xfer    = bit_vld_o & bit_rdy_i;
    assign w_idx_dec = idx_o - {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_x       <= '0;
            r_n       <= '0;
            r_cnt     <= '0;
            ready_o   <= 1'b1;
            bit_o     <= 1'b0;
            bit_vld_o <= 1'b0;
            last_o    <= 1'b0;
            len_o     <= '0;
            idx_o     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_x       <= w_x;
                        r_n       <= w_n;
                        r_cnt     <= w_n;
                        len_o     <= {w_n[CNT_W-2:0], 1'b1};
                        ready_o   <= 1'b0;
                        bit_vld_o <= 1'b1;
                        if (w_n != '0) begin
                            r_state <= S_PREFIX;
                            bit_o   <= 1'b0;
                            idx_o   <= '0;
                            last_o  <= 1'b0;
                        end else begin
                            r_state <= S_SUFFIX;
                            bit_o   <= w_x[0];
                            idx_o   <= '0;
                            last_o  <= 1'b1;
                        end
                    end
                end
                S_PREFIX: begin
                    if (w_xfer) begin
                        if (r_cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                            r_state <= S_SUFFIX;
                            bit_o   <= f_bit(r_x, r_n);
                            idx_o   <= r_n;
                            last_o  <= (r_n == '0);
                        end else begin
                            r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                S_SUFFIX: begin
                    if (w_xfer) begin
                        if (idx_o == '0) begin
                            r_state   <= S_IDLE;
                            ready_o   <= 1'b1;
                            bit_vld_o <= 1'b0;
                            bit_o     <= 1'b0;
                            last_o    <= 1'b0;
                        end else begin
                            idx_o  <= w_idx_dec;
                            bit_o  <= f_bit(r_x, w_idx_dec);
                            last_o <= (w_idx_dec == '0);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_enc_expgob.sv
// tb/tb_enc_expgob.sv - randomized bench for enc_expgob against an arithmetic Exp-Golomb model
module tb_enc_expgob;
    localparam int DATA_W = 8;
    localparam int CNT_W  = $clog2(2*DATA_W+2);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    logic [DATA_W-1:0] data_i = '0;
    logic              ready_o, bit_o, bit_vld_o, last_o;
    logic              bit_rdy_i = 1'b0;
    logic [CNT_W-1:0]  len_o, idx_o;

    int n_pass = 0;
    int n_total = 0;
    int exp_bit[$];
    int exp_idx[$];
    int exp_len;

    enc_expgob #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .data_i(data_i),
        .ready_o(ready_o), .bit_o(bit_o), .bit_vld_o(bit_vld_o), .bit_rdy_i(bit_rdy_i),
        .last_o(last_o), .len_o(len_o), .idx_o(idx_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Codeword from the definition: x = value+1, N = floor(log2 x), N zeros then x in N+1 bits
    task automatic build_model(input logic [DATA_W-1:0] v);
        int x, n, k;
`ifdef ENC_SIGNED_MAP_EN
        k = int'($signed(v));
        x = ((k > 0) ? (2*k - 1) : (-2*k)) + 1;
`else
        k = int'(v);
        x = k + 1;
`endif
        n = 0;
        while ((x >> (n+1)) != 0) n++;
        exp_bit.delete();
        exp_idx.delete();
        for (int i = 0; i < n; i++) begin
            exp_bit.push_back(0);
            exp_idx.push_back(0);
        end
        for (int i = n; i >= 0; i--) begin
            exp_bit.push_back((x >> i) & 1);
            exp_idx.push_back(i);
        end
        exp_len = 2*n + 1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, int'(ready_o), 1);
        check({tag, "_vld"}, int'(bit_vld_o), 0);
        check({tag, "_last"}, int'(last_o), 0);
        check({tag, "_bit"}, int'(bit_o), 0);
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1,..., 2: random ready and busy start pulses
    task automatic encode(input logic [DATA_W-1:0] v, input int mode, input int abort_after);
        int pos, cyc, wt;
        wt = 0;
        while (!ready_o && wt < 20) begin
            @(posedge clk); #1;
            wt++;
        end
        check("wait_ready", int'(ready_o), 1);
        build_model(v);
        start_i = 1'b1;
        data_i  = v;
        @(posedge clk); #1;
        start_i = 1'b0;
        data_i  = DATA_W'($urandom);
        pos = 0;
        cyc = 0;
        while (pos < exp_bit.size()) begin
            if (cyc > 400) begin
                check("timeout", 0, 1);
                return;
            end
            case (mode)
                0:       bit_rdy_i = 1'b1;
                1:       bit_rdy_i = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: bit_rdy_i = 1'($urandom_range(0, 1));
            endcase
            if (mode != 0) begin
                start_i = 1'($urandom_range(0, 1));
                data_i  = DATA_W'($urandom);
            end
            check("vld", int'(bit_vld_o), 1);
            check("ready_busy", int'(ready_o), 0);
            check("bit", int'(bit_o), exp_bit[pos]);
            check("idx", int'(idx_o), exp_idx[pos]);
            check("last", int'(last_o), (pos == exp_bit.size() - 1) ? 1 : 0);
            check("len", int'(len_o), exp_len);
            @(posedge clk); #1;
            cyc++;
            if (bit_rdy_i) begin
                pos++;
                if (abort_after > 0 && pos == abort_after) begin
                    start_i = 1'b0;
                    rst_n = 1'b0;
                    #1;
                    check_idle("abort");
                    check("abort_len", int'(len_o), 0);
                    check("abort_idx", int'(idx_o), 0);
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                    @(posedge clk); #1;
                    check("abort_still_idle", int'(bit_vld_o), 0);
                    return;
                end
            end
        end
        start_i   = 1'b0;
        bit_rdy_i = 1'b0;
        check_idle("post");
        check("post_len_hold", int'(len_o), exp_len);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        check("reset_len", int'(len_o), 0);
        check("reset_idx", int'(idx_o), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle("after_reset");

        encode(8'd0,   0, 0);
        encode(8'd3,   0, 0);
        encode(8'd255, 0, 0);
        encode(8'd6,   1, 0);
        encode(8'd100, 0, 3);
        encode(8'd1,   0, 0);
        encode(8'hFE,  0, 0);
        encode(8'h80,  2, 0);
        encode(8'h7F,  2, 0);
        for (int t = 0; t < 40; t++) begin
            encode(DATA_W'($urandom), 2, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
